add_scheduler: RTL and testbench
================================

ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 Parameter WIDTH, default 17: operand and sum bit width.
REQ-002 Parameter WIDTH1, default 9: LSB segment width of the split adder; the MSB segment is WIDTH-WIDTH1.
REQ-003 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester operation-pending flag.
REQ-007 req_x  input  NREQ*WIDTH  operand x; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_y  input  NREQ*WIDTH  operand y; same packing as req_x.
REQ-009 req_ready  output  NREQ  one-hot grant; a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high.
REQ-010 hold  input  1  when high, no new grants are issued; the pipeline keeps draining.
REQ-011 res_valid  output  1  one-cycle strobe marking a valid result.
REQ-012 res_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-013 res_sum  output  WIDTH  (x+y) mod 2^WIDTH.
REQ-014 busy  output  1  high while any operation is in flight.
REQ-015 issue_cnt  output  16  total accepted operations; wraps modulo 2^16.

Function
REQ-016 Grant is combinational from req_valid, hold and the priority pointer; req_ready SHALL be all-zero when hold=1 or req_valid=0.
REQ-017 At most one grant per cycle; at most one req_ready bit high.
REQ-018 Arbitration is round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-019 A requester holding req_valid continuously SHALL be granted within NREQ cycles while hold=0.
REQ-020 On a transfer, the granted operands are loaded into the adder input stage together with a tag {valid, id}.
REQ-021 Adder stage 1: LSB segment sum with carry-out is WIDTH1+1 bits wide; MSB segment sum is WIDTH-WIDTH1 bits wide.
REQ-022 Adder stage 2: LSBs pass through; the MSB result is the stage-1 MSB sum plus the LSB carry; the final carry is discarded.
REQ-023 Latency is fixed: a transfer in cycle t gives res_valid=1 with the matching res_id and res_sum in cycle t+3, for exactly one cycle.
REQ-024 The pipeline never stalls; one result per cycle is sustained under back-to-back transfers.
REQ-025 There is no result backpressure; consumers SHALL sample res_* whenever res_valid=1.
REQ-026 When res_valid=0, res_id and res_sum are don't-care, but SHALL not be X after reset.
REQ-027 busy = OR of the three tag-stage valid bits.
REQ-028 issue_cnt increments by 1 per transfer and wraps from 0xFFFF to 0x0000.
REQ-029 A hold rising in the same cycle as a request blocks that grant; in-flight results still emerge on schedule.
REQ-030 Operand changes on a non-granted requester have no effect.

Reset
REQ-031 While rst=1: every tag-stage valid bit, res_valid, busy and issue_cnt are 0; last_grant is NREQ-1, so requester 0 has first priority; data registers are 0.
REQ-032 A reset during operation discards all in-flight operations; no res_valid pulse is produced for them after reset is released.
REQ-033 The first grant can occur in the first cycle after rst deasserts.

Structure
REQ-034 A shared package add_pkg SHALL hold the default WIDTH/WIDTH1/NREQ values, the pipeline latency constant ADD_LAT=3 and the tag struct type {valid, id}.
REQ-035 The split two-stage adder with input registers SHALL be one sub-module, add_pipe2, with reset-clearable registers; arbitration, tag pipeline and counter stay in add_scheduler.

Verification
REQ-036 Single operation: requester 2 sends x=1, y=2 at cycle t -> in cycle t+3, res_valid=1, res_id=2, res_sum=3; issue_cnt=1.
REQ-037 Segment carry: x=0x001FF, y=0x00001 -> res_sum=0x00200; full overflow: x=0x1FFFF, y=0x00001 -> res_sum=0x00000.
REQ-038 Fairness: all four requesters valid continuously for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, and res_valid is high every cycle from t+3.
REQ-039 Hold: hold=1 for 3 cycles with all requesters valid -> req_ready=0 during hold, in-flight results still appear, and grants resume at the next requester in round-robin order.
REQ-040 Reset in flight: rst pulsed 1 cycle after two transfers -> no res_valid afterwards, busy=0, issue_cnt=0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared defaults, pipeline latency and tag type for the add scheduler.
package add_pkg;

  localparam int WIDTH_DEF  = 17;
  localparam int WIDTH1_DEF = 9;
  localparam int NREQ_DEF   = 4;
  localparam int ADD_LAT    = 3;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/add_pipe2.sv
// Split two-stage adder with an input register stage; fixed three-cycle latency.
module add_pipe2
  import add_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WIDTH1 = WIDTH1_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam int W2 = WIDTH - WIDTH1;

  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH1:0]  lsb_q, lsb_d;
  logic [W2-1:0]    msb_q, msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [W2-1:0]    carry_s;

  // Next-state for operand, segment-sum and final-sum registers.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = x_i;
      y_d = y_i;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    lsb_d   = {1'b0, x_q[WIDTH1-1:0]} + {1'b0, y_q[WIDTH1-1:0]};
    msb_d   = x_q[WIDTH-1:WIDTH1] + y_q[WIDTH-1:WIDTH1];
    carry_s = W2'(lsb_q[WIDTH1]);
    // Final carry out of the MSB segment is dropped: result is mod 2^WIDTH.
    sum_d   = {msb_q + carry_s, lsb_q[WIDTH1-1:0]};
  end

  // Pipeline registers; cleared so the result bus is never X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      lsb_q <= '0;
      msb_q <= '0;
      sum_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      lsb_q <= lsb_d;
      msb_q <= msb_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/add_scheduler.sv
// Round-robin arbiter feeding a shared pipelined adder; results carry the owner id.
module add_scheduler
  import add_pkg::*;
#(
  parameter int  WIDTH  = WIDTH_DEF,
  parameter int  WIDTH1 = WIDTH1_DEF,
  parameter int  NREQ   = NREQ_DEF,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  busy,
  output logic [15:0]           issue_cnt
);

  logic [IDW-1:0]   last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;
  tag_t             tag_q [ADD_LAT];
  tag_t             tag_d [ADD_LAT];
  logic             found_s;
  logic [IDW-1:0]   gid_s;
  logic [IDW:0]     cand_s;
  logic [WIDTH-1:0] x_sel_s, y_sel_s;
  logic             busy_s;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found_s = 1'b0;
    gid_s   = '0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_q} + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && !hold && req_valid[cand_s[IDW-1:0]]) begin
        found_s = 1'b1;
        gid_s   = cand_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign req_ready = found_s ? (NREQ'(1) << gid_s) : '0;
  assign x_sel_s   = req_x[gid_s*WIDTH +: WIDTH];
  assign y_sel_s   = req_y[gid_s*WIDTH +: WIDTH];

  // Pointer, counter and tag-pipeline next state.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (found_s) begin
      last_d = gid_s;
      cnt_d  = cnt_q + 16'd1;
    end else begin
      last_d = last_q;
      cnt_d  = cnt_q;
    end
    tag_d[0] = '{valid: found_s, id: TAG_ID_W'(gid_s)};
    for (int i = 1; i < ADD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Control state; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ-1);
      cnt_q  <= 16'd0;
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end

  // Any valid tag means an operation is still in flight.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < ADD_LAT; i++) begin
      busy_s = busy_s | tag_q[i].valid;
    end
  end

  add_pipe2 #(
    .WIDTH  (WIDTH),
    .WIDTH1 (WIDTH1)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .load_i (found_s),
    .x_i    (x_sel_s),
    .y_i    (y_sel_s),
    .sum_o  (res_sum)
  );

  assign res_valid = tag_q[ADD_LAT-1].valid;
  assign res_id    = tag_q[ADD_LAT-1].id[IDW-1:0];
  assign busy      = busy_s;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_add_scheduler.sv
// Randomized + directed scoreboard bench for add_scheduler with a behavioural reference.
module tb_add_scheduler;

  localparam int W  = 17;
  localparam int W1 = 9;
  localparam int N  = 4;
  localparam int L  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic [N-1:0]   req_ready;
  logic           hold = 1'b0;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_sum;
  logic           busy;
  logic [15:0]    issue_cnt;

  add_scheduler #(.WIDTH(W), .WIDTH1(W1), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .hold      (hold),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    int           due;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          started  = 1'b0;
  int          mlast    = N - 1;
  logic [15:0] mcnt     = 16'd0;
  bit          pend     = 1'b0;
  int          pend_id  = 0;

  // One bench cycle: commit last cycle's model transfer, drive, predict, check grant.
  task automatic do_cycle(input logic r, input logic h, input logic [N-1:0] v,
                          input logic [N*W-1:0] x, input logic [N*W-1:0] y, output int g);
    exp_t         e;
    logic [N-1:0] exp_ready;
    logic [W-1:0] xs, ys;
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      mcnt  = mcnt + 16'd1;
      mlast = pend_id;
      pend  = 1'b0;
    end
    rst = r; hold = h; req_valid = v; req_x = x; req_y = y;
    g = -1;
    if (r) begin
      sb.delete();
      mcnt  = 16'd0;
      mlast = N - 1;
    end
    #1;
    if (!r) begin
      if (!h) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mlast + k) % N;
          if (g < 0 && v[c]) g = c;
        end
      end
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      if (g >= 0) begin
        xs = x[g*W +: W];
        ys = y[g*W +: W];
        e.id  = g;
        e.sum = xs + ys;
        e.due = cyc + L;
        sb.push_back(e);
        pend    = 1'b1;
        pend_id = g;
      end
    end
  endtask

  // Monitor: compares results, busy and counter against the scoreboard each cycle.
  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      bit   exp_busy;
      exp_busy = (sb.size() > 0) && (sb[0].due - 2 <= cyc);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      checks++;
      if (issue_cnt !== mcnt) begin
        failures++;
        $display("FAIL issue_cnt cyc=%0d got=%0d exp=%0d", cyc, issue_cnt, mcnt);
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result cyc=%0d got id=%0d sum=%h exp none", cyc, res_id, res_sum);
        end else begin
          e = sb.pop_front();
          if (res_id !== 2'(e.id) || res_sum !== e.sum || cyc != e.due) begin
            failures++;
            $display("FAIL result cyc=%0d got id=%0d sum=%h exp id=%0d sum=%h at cyc=%0d",
                     cyc, res_id, res_sum, e.id, e.sum, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("FAIL missing_result cyc=%0d got res_valid=%b exp id=%0d sum=%h", cyc, res_valid, e.id, e.sum);
      end
    end
  end

  logic [N*W-1:0] zx = '0;
  logic [N*W-1:0] rx, ry, dx, dy;
  int             g;

  initial begin
    do_cycle(1'b1, 1'b0, '0, zx, zx, g);
    do_cycle(1'b1, 1'b0, '0, zx, zx, g);
    started = 1'b1;
    checks++;
    if ($isunknown({res_id, res_sum}) || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b id=%b sum=%b exp valid=0 no X", res_valid, res_id, res_sum);
    end

    // Single operation on requester 2: 1 + 2.
    dx = zx; dy = zx;
    dx[2*W +: W] = 17'd1;
    dy[2*W +: W] = 17'd2;
    do_cycle(1'b0, 1'b0, 4'b0100, dx, dy, g);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);
    checks++;
    if (issue_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_cnt got=%0d exp=1", issue_cnt);
    end

    // Segment carry and full overflow on requester 0.
    dx = zx; dy = zx;
    dx[0 +: W] = 17'h001FF; dy[0 +: W] = 17'h00001;
    do_cycle(1'b0, 1'b0, 4'b0001, dx, dy, g);
    dx[0 +: W] = 17'h1FFFF;
    do_cycle(1'b0, 1'b0, 4'b0001, dx, dy, g);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);

    // Fairness from reset: grants must rotate 0,1,2,3,0,1,2,3.
    do_cycle(1'b1, 1'b0, '0, zx, zx, g);
    for (int i = 0; i < 8; i++) begin
      rx = N*W'({$urandom(), $urandom(), $urandom()});
      ry = N*W'({$urandom(), $urandom(), $urandom()});
      do_cycle(1'b0, 1'b0, 4'b1111, rx, ry, g);
      checks++;
      if (req_ready !== (4'b0001 << (i % N))) begin
        failures++;
        $display("FAIL fairness i=%0d got=%b exp=%b", i, req_ready, 4'b0001 << (i % N));
      end
    end
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);

    // Hold for 3 cycles with everyone requesting; grants resume at requester 2.
    do_cycle(1'b1, 1'b0, '0, zx, zx, g);
    do_cycle(1'b0, 1'b0, 4'b1111, rx, ry, g);
    do_cycle(1'b0, 1'b0, 4'b1111, ry, rx, g);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 4'b1111, rx, ry, g);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL hold_ready i=%0d got=%b exp=0000", i, req_ready);
      end
    end
    do_cycle(1'b0, 1'b0, 4'b1111, rx, ry, g);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL hold_resume got=%b exp=0100", req_ready);
    end
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);

    // Reset one cycle after two transfers: nothing may emerge afterwards.
    do_cycle(1'b0, 1'b0, 4'b0011, rx, ry, g);
    do_cycle(1'b0, 1'b0, 4'b0011, rx, ry, g);
    do_cycle(1'b1, 1'b0, '0, zx, zx, g);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);
    checks++;
    if (busy !== 1'b0 || issue_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_flight got busy=%b cnt=%0d exp busy=0 cnt=0", busy, issue_cnt);
    end

    // Randomized traffic with occasional hold and reset.
    for (int i = 0; i < 2000; i++) begin
      rx = N*W'({$urandom(), $urandom(), $urandom()});
      ry = N*W'({$urandom(), $urandom(), $urandom()});
      do_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
               N'($urandom()), rx, ry, g);
    end

    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, '0, zx, zx, g);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
